// File: rtl/serial_read_buffer.sv
// Serial-to-parallel capture: samples in_line on read_sig strobes into a BUF_SIZE word.
// Optional sticky overrun flag when SERIAL_READ_BUF_OVERRUN_EN is defined.
module serial_read_buffer #(
  parameter int BUF_SIZE   = 8,
  parameter int LSB_FIRST  = 0,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          read_sig,
  input  logic [$clog2(BUF_SIZE+1)-1:0] read_count,
  input  logic                          in_line,
  output logic [BUF_SIZE-1:0]           data_out,
  output logic                          done_sig
`ifdef SERIAL_READ_BUF_OVERRUN_EN
  ,output logic                         overrun
`endif
);

  localparam int CW = $clog2(BUF_SIZE + 1);
  localparam int IW = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
  localparam logic [CW-1:0] MAX_CNT   = CW'(BUF_SIZE);
  localparam logic [IW-1:0] IDX_START = (LSB_FIRST != 0) ? '0 : IW'(BUF_SIZE - 1);
  localparam logic          INV       = (ACTIVE_LOW != 0);

  typedef enum logic {IDLE, READ} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [BUF_SIZE-1:0] data_q;
  logic [CW-1:0]       cnt_clamped;
  logic                load, capture;

  assign cnt_clamped = (read_count > MAX_CNT) ? MAX_CNT : read_count;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        // read_sig coinciding with an accepted start is deliberately dropped
        if (start) begin
          load = 1'b1;
          if (cnt_clamped != '0) state_nxt = READ;
        end
      end
      READ: begin
        if (read_sig) begin
          capture = 1'b1;
          if (cnt == CW'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      data_q <= '0;
    end else if (load) begin
      cnt    <= cnt_clamped;
      idx    <= IDX_START;
      data_q <= '0;
    end else if (capture) begin
      data_q[idx] <= in_line ^ INV;
      idx         <= (LSB_FIRST != 0) ? idx + IW'(1) : idx - IW'(1);
      cnt         <= cnt - CW'(1);
    end
  end

  assign data_out = data_q;
  assign done_sig = (state == IDLE);

`ifdef SERIAL_READ_BUF_OVERRUN_EN
  logic word_ready;

  // Extra strobes only count as overrun once a transfer has actually finished
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      word_ready <= 1'b0;
      overrun    <= 1'b0;
    end else if (load) begin
      word_ready <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (capture && state_nxt == IDLE) word_ready <= 1'b1;
      if (state == IDLE && read_sig && word_ready) overrun <= 1'b1;
    end
  end
`endif

endmodule
